// File: rtl/ft2_tx_fifo.sv
// Byte FIFO feeding an FT245-style asynchronous write port (TXE#/WR#).
// Each byte is sent as SETUP, STROBE (WR_PULSE cycles), HOLD and RECOVER, and the bus is then released.
module ft2_tx_fifo #(
    parameter int PTR_W    = 4,
    parameter int WR_PULSE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             txe_n_in,
    output logic             wr_n_out,
    output logic [7:0]       ft2_data_out,
    output logic             ft2_data_oe,
    output logic [PTR_W:0]   level,
    output logic             tx_busy
);

    localparam logic [PTR_W:0]   DEPTH     = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0]   LVL_ZERO  = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   LVL_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [3:0]       CNT_LAST  = 4'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_n_q, wr_n_d;
    logic             oe_q, oe_d;
    logic [7:0]       data_q, data_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [1:0]       sync_q;
    logic [7:0]       mem_q [2**PTR_W];

    logic             txe_ok_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;

    assign txe_ok_s   = sync_q[1];
    assign in_ready_s = (level_q != DEPTH);
    assign push_s     = in_valid && in_ready_s;

    // Transmit sequencer; the RECOVER cycle plus the following IDLE cycle form the two-cycle bus-release gap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_n_d  = 1'b1;
        oe_d    = oe_q;
        data_d  = data_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (txe_ok_s && (level_q != LVL_ZERO)) begin
                    state_d = SETUP;
                    pop_s   = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    oe_d    = 1'b1;
                end else begin
                    oe_d    = 1'b0;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 4'd0;
                wr_n_d  = 1'b0;
                oe_d    = 1'b1;
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    wr_n_d  = 1'b0;
                end
            end
            HOLD: begin
                state_d = RECOVER;
                oe_d    = 1'b0;
            end
            RECOVER: begin
                state_d = IDLE;
                oe_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    // Pointer and occupancy update; a pop never coincides with a push into a full FIFO
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // State, output and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_n_q   <= 1'b1;
            oe_q     <= 1'b0;
            data_q   <= 8'h00;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= LVL_ZERO;
            sync_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_n_q   <= wr_n_d;
            oe_q     <= oe_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sync_q   <= {sync_q[0], ~txe_n_in};
        end
    end

    // Storage array; contents are meaningless after reset because the pointers restart
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready     = in_ready_s;
    assign wr_n_out     = wr_n_q;
    assign ft2_data_out = data_q;
    assign ft2_data_oe  = oe_q;
    assign level        = level_q;
    assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ft2_tx_fifo.sv
// Self-checking bench for ft2_tx_fifo: directed scenarios plus a randomized stream,
// with a byte-order scoreboard and an occupancy/strobe-shape reference model.
module tb_ft2_tx_fifo;

    localparam int PW    = 4;
    localparam int WP    = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          txe_n_in = 1'b1;
    logic          wr_n_out;
    logic [7:0]    ft2_data_out;
    logic          ft2_data_oe;
    logic [PW:0]   level;
    logic          tx_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_emit = 0;

    // reference model state, maintained at the falling edge
    logic [7:0] exp_q[$];
    int  npush = 0, npop = 0, mlevel = 0;
    int  low_len = 0, oe_run = 0;
    bit  prev_wr = 1'b1, prev_oe = 1'b0, was_rst = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] sb_b;

    ft2_tx_fifo #(.PTR_W(PW), .WR_PULSE(WP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .txe_n_in(txe_n_in), .wr_n_out(wr_n_out),
        .ft2_data_out(ft2_data_out), .ft2_data_oe(ft2_data_oe),
        .level(level), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // Model: level = accepted pushes - pops (a pop is the start of a bus cycle), in-order bytes, strobe shape
    always @(negedge clk) begin
        if (was_rst) begin
            exp_q.delete(); npush = 0; npop = 0; prev_wr = 1'b1; prev_oe = 1'b0;
            prev_data = 8'h00; low_len = 0; oe_run = 0;
        end
        if (!rst) begin
            if (ft2_data_oe && !prev_oe) npop++;
            oe_run = ft2_data_oe ? oe_run + 1 : 0;
            mlevel = npush - npop;
            n_vec++;
            if (level !== (PW+1)'(mlevel))
                begin n_err++; $display("FAIL mon_level: got %0d want %0d", level, mlevel); end
            n_vec++;
            if (in_ready !== (mlevel != DEPTH))
                begin n_err++; $display("FAIL mon_ready: got %b want %b", in_ready, mlevel != DEPTH); end
            n_vec++;
            if (!wr_n_out && !ft2_data_oe)
                begin n_err++; $display("FAIL mon_wr_without_oe: wr_n=%b oe=%b", wr_n_out, ft2_data_oe); end
            if (!wr_n_out) begin
                if (prev_wr) begin
                    n_emit++;
                    low_len = 1;
                    n_vec++;
                    if (oe_run != 2)
                        begin n_err++; $display("FAIL mon_oe_lead: oe high %0d cycles at wr fall, want 2", oe_run); end
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++; $display("FAIL mon_sb_empty: byte %h emitted, none expected", ft2_data_out);
                    end else begin
                        sb_b = exp_q.pop_front();
                        if (ft2_data_out !== sb_b)
                            begin n_err++; $display("FAIL mon_sb_data: got %h want %h", ft2_data_out, sb_b); end
                    end
                end else begin
                    low_len++;
                    n_vec++;
                    if (ft2_data_out !== prev_data)
                        begin n_err++; $display("FAIL mon_data_stable: got %h want %h", ft2_data_out, prev_data); end
                end
            end else if (!prev_wr) begin
                n_vec++;
                if (low_len != WP)
                    begin n_err++; $display("FAIL mon_pulse_len: got %0d want %0d", low_len, WP); end
            end
            if (in_valid && (mlevel != DEPTH)) begin
                exp_q.push_back(in_data);
                npush++;
            end
            prev_wr = wr_n_out; prev_oe = ft2_data_oe; prev_data = ft2_data_out;
        end
        was_rst = rst;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 200; t++) begin
            if (!tx_busy && level == 0) break;
            cyc();
        end
        n_vec++;
        if (t == 200) begin n_err++; $display("FAIL wait_idle: timeout busy=%b level=%0d", tx_busy, level); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        n_vec++;
        if ({wr_n_out, ft2_data_oe, ft2_data_out, level, tx_busy} !== {1'b1, 1'b0, 8'h00, 5'd0, 1'b0})
            begin n_err++; $display("FAIL reset_state: wr_n=%b oe=%b data=%h level=%0d busy=%b, want 1 0 00 0 0",
                                    wr_n_out, ft2_data_oe, ft2_data_out, level, tx_busy); end
        cyc();
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        txe_n_in = 1'b0;
        repeat (4) cyc();
        in_valid = 1'b1; in_data = 8'hA5;
        cyc();
        in_valid = 1'b0;
        n_vec++;
        if (level !== 5'd1 || ft2_data_oe !== 1'b0)
            begin n_err++; $display("FAIL single_push: level=%0d oe=%b want 1 0", level, ft2_data_oe); end
        cyc();
        n_vec++;
        if ({ft2_data_oe, wr_n_out, ft2_data_out, level, tx_busy} !== {1'b1, 1'b1, 8'hA5, 5'd0, 1'b1})
            begin n_err++; $display("FAIL single_setup: oe=%b wr_n=%b data=%h level=%0d busy=%b want 1 1 a5 0 1",
                                    ft2_data_oe, wr_n_out, ft2_data_out, level, tx_busy); end
        cyc();
        n_vec++;
        if (wr_n_out !== 1'b0) begin n_err++; $display("FAIL single_strobe1: wr_n=%b want 0", wr_n_out); end
        cyc();
        n_vec++;
        if (wr_n_out !== 1'b0) begin n_err++; $display("FAIL single_strobe2: wr_n=%b want 0", wr_n_out); end
        cyc();
        n_vec++;
        if (wr_n_out !== 1'b1 || ft2_data_oe !== 1'b1 || ft2_data_out !== 8'hA5)
            begin n_err++; $display("FAIL single_hold: wr_n=%b oe=%b data=%h want 1 1 a5", wr_n_out, ft2_data_oe, ft2_data_out); end
        cyc();
        n_vec++;
        if (ft2_data_oe !== 1'b0 || tx_busy !== 1'b1)
            begin n_err++; $display("FAIL single_recover: oe=%b busy=%b want 0 1", ft2_data_oe, tx_busy); end
        cyc();
        n_vec++;
        if (tx_busy !== 1'b0 || ft2_data_oe !== 1'b0)
            begin n_err++; $display("FAIL single_idle: busy=%b oe=%b want 0 0", tx_busy, ft2_data_oe); end
    endtask

    task automatic test_fill();
        int k, tlast, t;
        bit pw, seen;
        txe_n_in = 1'b1;
        wait_idle();
        repeat (3) cyc();
        for (int i = 0; i <= DEPTH; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            n_vec++;
            if (in_ready !== (i < DEPTH))
                begin n_err++; $display("FAIL fill_ready[%0d]: got %b want %b", i, in_ready, i < DEPTH); end
            cyc();
        end
        n_vec++;
        if (level !== 5'd16 || in_ready !== 1'b0)
            begin n_err++; $display("FAIL fill_full: level=%0d ready=%b want 16 0", level, in_ready); end
        txe_n_in = 1'b0;
        seen = 1'b0;
        for (t = 0; t < 10; t++) begin
            cyc();
            if (ft2_data_oe) begin seen = 1'b1; break; end
        end
        in_valid = 1'b0;
        n_vec++;
        if (!seen || level !== 5'd15)
            begin n_err++; $display("FAIL full_pop_push: oe_seen=%b level=%0d want 1 15", seen, level); end
        k = 0; tlast = 0; pw = wr_n_out;
        for (t = 0; t < 200 && k < DEPTH; t++) begin
            cyc();
            if (!wr_n_out && pw) begin
                n_vec++;
                if (ft2_data_out !== 8'(k))
                    begin n_err++; $display("FAIL fill_order[%0d]: got %h want %h", k, ft2_data_out, 8'(k)); end
                if (k > 0) begin
                    n_vec++;
                    if (t - tlast != 4 + WP)
                        begin n_err++; $display("FAIL fill_spacing[%0d]: got %0d want %0d", k, t - tlast, 4 + WP); end
                end
                tlast = t; k++;
            end
            pw = wr_n_out;
        end
        n_vec++;
        if (k != DEPTH) begin n_err++; $display("FAIL fill_count: got %0d want %0d", k, DEPTH); end
        wait_idle();
    endtask

    task automatic test_txe_drop();
        logic [7:0] b1;
        int t;
        b1 = 8'($urandom);
        txe_n_in = 1'b0;
        repeat (3) cyc();
        in_valid = 1'b1; in_data = 8'($urandom);
        cyc();
        in_data = b1;
        cyc();
        in_valid = 1'b0;
        for (t = 0; t < 10; t++) begin
            if (!wr_n_out) break;
            cyc();
        end
        txe_n_in = 1'b1;
        cyc();
        n_vec++;
        if (wr_n_out !== 1'b0) begin n_err++; $display("FAIL drop_strobe2: wr_n=%b want 0", wr_n_out); end
        cyc();
        n_vec++;
        if (wr_n_out !== 1'b1 || ft2_data_oe !== 1'b1)
            begin n_err++; $display("FAIL drop_hold: wr_n=%b oe=%b want 1 1", wr_n_out, ft2_data_oe); end
        cyc();
        n_vec++;
        if (ft2_data_oe !== 1'b0 || tx_busy !== 1'b1)
            begin n_err++; $display("FAIL drop_recover: oe=%b busy=%b want 0 1", ft2_data_oe, tx_busy); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_vec++;
            if (wr_n_out !== 1'b1 || ft2_data_oe !== 1'b0 || level !== 5'd1)
                begin n_err++; $display("FAIL drop_wait[%0d]: wr_n=%b oe=%b level=%0d want 1 0 1",
                                        i, wr_n_out, ft2_data_oe, level); end
        end
        txe_n_in = 1'b0;
        for (t = 0; t < 10; t++) begin
            cyc();
            if (!wr_n_out) break;
        end
        n_vec++;
        if (wr_n_out !== 1'b0 || ft2_data_out !== b1)
            begin n_err++; $display("FAIL drop_resume: wr_n=%b data=%h want 0 %h", wr_n_out, ft2_data_out, b1); end
        wait_idle();
    endtask

    task automatic test_reset_strobe();
        int t;
        txe_n_in = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        for (t = 0; t < 10; t++) begin
            if (!wr_n_out) break;
            cyc();
        end
        n_vec++;
        if (wr_n_out !== 1'b0 || level !== 5'd3)
            begin n_err++; $display("FAIL rststb_pre: wr_n=%b level=%0d want 0 3", wr_n_out, level); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_vec++;
        if ({wr_n_out, ft2_data_oe, level, tx_busy} !== {1'b1, 1'b0, 5'd0, 1'b0})
            begin n_err++; $display("FAIL rststb_post: wr_n=%b oe=%b level=%0d busy=%b want 1 0 0 0",
                                    wr_n_out, ft2_data_oe, level, tx_busy); end
        cyc();
        n_vec++;
        if (in_ready !== 1'b1 || level !== 5'd0)
            begin n_err++; $display("FAIL rststb_ready: ready=%b level=%0d want 1 0", in_ready, level); end
    endtask

    task automatic test_stream();
        int idx, start_emit, t;
        bit v, rdy;
        idx = 0;
        start_emit = n_emit;
        for (t = 0; t < 3000 && idx < 40; t++) begin
            v = ($urandom_range(0, 9) < 7);
            in_valid = v;
            in_data  = 8'($urandom);
            txe_n_in = ($urandom_range(0, 9) == 0);
            rdy = in_ready;
            cyc();
            if (v && rdy) idx++;
        end
        in_valid = 1'b0;
        txe_n_in = 1'b0;
        n_vec++;
        if (idx != 40) begin n_err++; $display("FAIL stream_push: pushed %0d want 40", idx); end
        wait_idle();
        cyc();
        n_vec++;
        if (n_emit - start_emit != 40 || exp_q.size() != 0)
            begin n_err++; $display("FAIL stream_emit: emitted %0d left %0d want 40 0", n_emit - start_emit, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_txe_drop();
        test_reset_strobe();
        test_stream();
        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
